// File: rtl/branch_station_multi.sv
// rtl/branch_station_multi.sv - branch reservation station with CDB wakeup and oldest-ready issue
// Optional perf_mispred counter enabled by BRANCH_STATION_PERF_EN.
module branch_station_multi #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int ROB_W  = 4,
    parameter int NCDB   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [TAG_W-1:0]        in_tag1,
    input  logic [DATA_W-1:0]       in_data1,
    input  logic [TAG_W-1:0]        in_tag2,
    input  logic [DATA_W-1:0]       in_data2,
    input  logic [ROB_W-1:0]        in_rob,
    input  logic                    in_pred,
    input  logic [NCDB-1:0]         cdb_valid,
    input  logic [NCDB*TAG_W-1:0]   cdb_tag,
    input  logic [NCDB*DATA_W-1:0]  cdb_data,
    output logic                    out_valid,
    output logic [ROB_W-1:0]        out_rob,
    output logic [1:0]              out_result
`ifdef BRANCH_STATION_PERF_EN
    ,
    output logic [31:0]             perf_mispred
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0]  vld;
    logic [2:0]        op_q   [DEPTH];
    logic [TAG_W-1:0]  tag1_q [DEPTH];
    logic [TAG_W-1:0]  tag2_q [DEPTH];
    logic [DATA_W-1:0] d1_q   [DEPTH];
    logic [DATA_W-1:0] d2_q   [DEPTH];
    logic [ROB_W-1:0]  rob_q  [DEPTH];
    logic [DEPTH-1:0]  pred_q;
    // older[j][i] set means entry j was dispatched before entry i
    logic [DEPTH-1:0]  older  [DEPTH];

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  free_idx;
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  blk;
    logic              iss_valid;
    logic [IDX_W-1:0]  iss_idx;
    logic              iss_taken;
    logic              do_disp;
    logic [DEPTH-1:0]  wk1_hit, wk2_hit;
    logic [DATA_W-1:0] wk1_data [DEPTH];
    logic [DATA_W-1:0] wk2_data [DEPTH];
    logic              by1_hit, by2_hit;
    logic [DATA_W-1:0] by1_data, by2_data;

    // Lowest-index matching port wins; tag 0 never matches.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] t);
        cdb_lookup = '0;
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && t != '0 && cdb_tag[p*TAG_W +: TAG_W] == t)
                cdb_lookup = {1'b1, cdb_data[p*DATA_W +: DATA_W]};
        end
    endfunction

    function automatic logic branch_taken(input logic [2:0] op,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
        case (op)
            3'b000:  branch_taken = (a == b);
            3'b001:  branch_taken = (a != b);
            3'b100:  branch_taken = ($signed(a) <  $signed(b));
            3'b101:  branch_taken = ($signed(a) >= $signed(b));
            3'b110:  branch_taken = (a <  b);
            3'b111:  branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    always_comb begin
        cnt      = '0;
        free_idx = '0;
        ready    = '0;
        blk      = '0;
        iss_valid = 1'b0;
        iss_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld[i])
                free_idx = IDX_W'(i);
            cnt = cnt + CNT_W'(vld[i]);
            ready[i] = vld[i] && tag1_q[i] == '0 && tag2_q[i] == '0;
            {wk1_hit[i], wk1_data[i]} = cdb_lookup(tag1_q[i]);
            {wk2_hit[i], wk2_data[i]} = cdb_lookup(tag2_q[i]);
        end
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
                if (ready[j] && older[j][i])
                    blk[i] = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i] && !blk[i]) begin
                iss_valid = 1'b1;
                iss_idx   = IDX_W'(i);
            end
        end
        iss_taken = branch_taken(op_q[iss_idx], d1_q[iss_idx], d2_q[iss_idx]);
        in_ready  = (cnt < DEPTH_C);
        do_disp   = in_valid && in_ready;
        {by1_hit, by1_data} = cdb_lookup(in_tag1);
        {by2_hit, by2_data} = cdb_lookup(in_tag2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld        <= '0;
            out_valid  <= 1'b0;
            out_rob    <= '0;
            out_result <= '0;
        end else if (flush) begin
            vld       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= iss_valid;
            if (iss_valid) begin
                out_rob      <= rob_q[iss_idx];
                out_result   <= {pred_q[iss_idx], iss_taken};
                vld[iss_idx] <= 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && wk1_hit[i]) begin
                    tag1_q[i] <= '0;
                    d1_q[i]   <= wk1_data[i];
                end
                if (vld[i] && wk2_hit[i]) begin
                    tag2_q[i] <= '0;
                    d2_q[i]   <= wk2_data[i];
                end
            end
            if (do_disp) begin
                vld[free_idx]    <= 1'b1;
                op_q[free_idx]   <= in_op;
                tag1_q[free_idx] <= by1_hit ? '0 : in_tag1;
                d1_q[free_idx]   <= by1_hit ? by1_data : in_data1;
                tag2_q[free_idx] <= by2_hit ? '0 : in_tag2;
                d2_q[free_idx]   <= by2_hit ? by2_data : in_data2;
                rob_q[free_idx]  <= in_rob;
                pred_q[free_idx] <= in_pred;
                older[free_idx]  <= '0;
                for (int j = 0; j < DEPTH; j++)
                    if (j != int'(free_idx))
                        older[j][free_idx] <= vld[j];
            end
        end
    end

`ifdef BRANCH_STATION_PERF_EN
    // Flush drops the issue, so the counter only advances alongside a real out_valid.
    always_ff @(posedge clk) begin
        if (rst)
            perf_mispred <= '0;
        else if (!flush && iss_valid && pred_q[iss_idx] != iss_taken && perf_mispred != '1)
            perf_mispred <= perf_mispred + 32'd1;
    end
`endif

endmodule

// File: tb/tb_branch_station_multi.sv
// tb/tb_branch_station_multi.sv - randomized and directed bench for branch_station_multi against a queue model
module tb_branch_station_multi;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_tag1, in_tag2;
    logic [31:0] in_data1, in_data2;
    logic [3:0]  in_rob;
    logic        in_pred;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        out_valid;
    logic [3:0]  out_rob;
    logic [1:0]  out_result;
`ifdef BRANCH_STATION_PERF_EN
    logic [31:0] perf_mispred;
`endif

    branch_station_multi dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_tag1(in_tag1), .in_data1(in_data1), .in_tag2(in_tag2), .in_data2(in_data2),
        .in_rob(in_rob), .in_pred(in_pred),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_rob(out_rob), .out_result(out_result)
`ifdef BRANCH_STATION_PERF_EN
        , .perf_mispred(perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  t1, t2;
        logic [31:0] d1, d2;
        logic [3:0]  rob;
        logic        pred;
    } ent_t;

    ent_t        q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic        exp_v;
    logic [3:0]  exp_rob;
    logic [1:0]  exp_res;
    logic [31:0] exp_perf = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return !($signed(a) < $signed(b));
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit cdb_hit(input logic [3:0] t, output logic [31:0] d);
        d = '0;
        if (t == 0) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (cdb_valid[p] && cdb_tag[p*4 +: 4] == t) begin
                d = cdb_data[p*32 +: 32];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic idle_in();
        flush = 0; in_valid = 0; in_op = 0; in_tag1 = 0; in_tag2 = 0;
        in_data1 = 0; in_data2 = 0; in_rob = 0; in_pred = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic disp(input logic [2:0] op, input logic [3:0] t1, input logic [31:0] d1,
                        input logic [3:0] t2, input logic [31:0] d2, input logic [3:0] rob, input logic pred);
        in_valid = 1; in_op = op; in_tag1 = t1; in_data1 = d1;
        in_tag2 = t2; in_data2 = d2; in_rob = rob; in_pred = pred;
    endtask

    // Advance one clock: model the spec rules on a dispatch-ordered queue, then compare.
    task automatic step();
        bit          rdy;
        int          idx;
        logic [31:0] d;
        bit          tk;
        ent_t        e;
        rdy = q.size() < DEPTH;
        check("in_ready", in_ready, rdy);
        idx = -1;
        foreach (q[i]) if (idx < 0 && q[i].t1 == 0 && q[i].t2 == 0) idx = i;
        if (flush) begin
            q.delete();
            exp_v = 0;
        end else begin
            exp_v = 0;
            if (idx >= 0) begin
                tk = ref_taken(q[idx].op, q[idx].d1, q[idx].d2);
                exp_v = 1;
                exp_rob = q[idx].rob;
                exp_res = {q[idx].pred, tk};
                if (q[idx].pred != tk && exp_perf != 32'hFFFF_FFFF) exp_perf++;
                q.delete(idx);
            end
            foreach (q[i]) begin
                if (cdb_hit(q[i].t1, d)) begin q[i].t1 = 0; q[i].d1 = d; end
                if (cdb_hit(q[i].t2, d)) begin q[i].t2 = 0; q[i].d2 = d; end
            end
            if (in_valid && rdy) begin
                e = '{op: in_op, t1: in_tag1, t2: in_tag2, d1: in_data1, d2: in_data2, rob: in_rob, pred: in_pred};
                if (cdb_hit(e.t1, d)) begin e.t1 = 0; e.d1 = d; end
                if (cdb_hit(e.t2, d)) begin e.t2 = 0; e.d2 = d; end
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, exp_v);
        if (exp_v) begin
            check("out_rob", out_rob, exp_rob);
            check("out_result", out_result, exp_res);
        end
`ifdef BRANCH_STATION_PERF_EN
        check("perf_mispred", perf_mispred, exp_perf);
`endif
    endtask

    initial begin
        rst = 1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_rob", out_rob, 0);
        check("rst_out_result", out_result, 0);
        step();

        // BEQ 5==5, pred 0 -> {0,1}
        disp(3'b000, 0, 5, 0, 5, 3, 0);
        step();
        idle_in();
        step();
        check("beq_valid", out_valid, 1);
        check("beq_rob", out_rob, 3);
        check("beq_result", out_result, 2'b01);
        step();

        // BLT waiting on tag 2, woken by port 1 with -1
        disp(3'b100, 2, 0, 0, 0, 1, 0);
        step();
        idle_in();
        cdb_valid = 2'b10; cdb_tag = {4'd2, 4'd0}; cdb_data = {32'hFFFF_FFFF, 32'd0};
        step();
        idle_in();
        step();
        check("blt_valid", out_valid, 1);
        check("blt_rob", out_rob, 1);
        check("blt_result", out_result, 2'b01);
        step();

        // Fill with waiting entries, push while full, wake all at once
        for (int i = 0; i < DEPTH; i++) begin
            disp(3'($urandom_range(0, 7)), 5, $urandom, 0, $urandom, 4'(4 + i), 1'($urandom_range(0, 1)));
            step();
        end
        disp(3'b000, 0, 1, 0, 1, 15, 0);
        step();
        check("full_in_ready", in_ready, 0);
        idle_in();
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_data = {32'd0, 32'h8000_0000};
        step();
        idle_in();
        repeat (DEPTH + 2) step();

        // Dispatch-time bypass on tag 7 from port 0
        disp(3'b001, 0, 9, 7, 0, 2, 0);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_data = {32'd0, 32'd9};
        step();
        idle_in();
        step();
        check("bnebyp_valid", out_valid, 1);
        check("bnebyp_rob", out_rob, 2);
        check("bnebyp_result", out_result, 2'b00);
        step();

        // Flush with a held dispatch
        disp(3'b000, 9, 0, 0, 0, 6, 1); step();
        disp(3'b001, 0, 0, 9, 0, 8, 0); step();
        disp(3'b000, 0, 3, 0, 3, 10, 0);
        flush = 1;
        step();
        idle_in();
        check("flush_valid", out_valid, 0);
        check("flush_ready", in_ready, 1);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd9}; cdb_data = 0;
        step();
        idle_in();
        repeat (3) begin
            step();
            check("flush_noissue", out_valid, 0);
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_op    = 3'($urandom_range(0, 7));
            in_tag1  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 3));
            in_tag2  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 3));
            in_data1 = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            in_data2 = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            in_rob   = 4'($urandom_range(0, 15));
            in_pred  = 1'($urandom_range(0, 1));
            cdb_valid = 2'($urandom_range(0, 3));
            cdb_tag  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            cdb_data = {32'($urandom_range(0, 1) ? $urandom : 32'hFFFF_FFFE), 32'($urandom_range(0, 4))};
            flush    = ($urandom_range(0, 63) == 0);
            step();
        end
        idle_in();
        repeat (DEPTH + 2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
